// File: rtl/hd44780_pkg.sv
// Shared FSM state type, LCD command bytes and the power-on init ROM for the
// 8-bit HD44780 write-only controller.
package hd44780_pkg;

   typedef enum logic [2:0] {
      POWERUP   = 3'd0,
      INIT_LOAD = 3'd1,
      IDLE      = 3'd2,
      SETUP     = 3'd3,
      E_HIGH    = 3'd4,
      HOLD      = 3'd5,
      EXEC_WAIT = 3'd6
   } state_e;

   localparam logic [7:0] CMD_FUNC_SET_8B2L = 8'h38;
   localparam logic [7:0] CMD_DISPLAY_ON    = 8'h0C;
   localparam logic [7:0] CMD_CLEAR         = 8'h01;
   localparam logic [7:0] CMD_ENTRY_INC     = 8'h06;

   localparam int unsigned INIT_LEN = 7;

   function automatic logic [7:0] init_rom(input logic [2:0] idx);
      logic [7:0] b;
      case (idx)
         3'd0, 3'd1, 3'd2, 3'd3: b = CMD_FUNC_SET_8B2L;
         3'd4:                   b = CMD_DISPLAY_ON;
         3'd5:                   b = CMD_CLEAR;
         3'd6:                   b = CMD_ENTRY_INC;
         default:                b = CMD_FUNC_SET_8B2L;
      endcase
      return b;
   endfunction

   // Clear and return-home commands need the long execution wait.
   function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
      return (rs == 1'b0) && ((data == 8'h01) || (data == 8'h02) || (data == 8'h03));
   endfunction

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/hd44780_delay_timer.sv
// Loadable down-counter: takes a value on load, counts down to zero and
// parks there; done is high whenever the count is zero.
module hd44780_delay_timer #(
   parameter int unsigned P_WIDTH = 8
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_load,
   input  logic [P_WIDTH-1:0] i_value,
   output logic [P_WIDTH-1:0] o_value,
   output logic               o_done
);

   localparam logic [P_WIDTH-1:0] ONE  = P_WIDTH'(1);
   localparam logic [P_WIDTH-1:0] ZERO = {P_WIDTH{1'b0}};

   logic [P_WIDTH-1:0] count_q;
   logic [P_WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (i_load) begin
         count_d = i_value;
      end else if (count_q != ZERO) begin
         count_d = count_q - ONE;
      end else begin
         count_d = count_q;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         count_q <= ZERO;
      end else begin
         count_q <= count_d;
      end
   end

   assign o_value = count_q;
   assign o_done  = (count_q == ZERO);

endmodule

// File: rtl/hd44780_controller.sv
// HD44780 8-bit write controller: runs the power-on init ROM, then accepts
// command/data bytes and strobes them onto the LCD with the required timing.
module hd44780_controller
   import hd44780_pkg::*;
#(
   parameter int unsigned P_E_HIGH_CYC  = 7,
   parameter int unsigned P_POWERUP_CYC = 200000,
   parameter int unsigned P_INIT1_CYC   = 50000,
   parameter int unsigned P_INIT2_CYC   = 1200,
   parameter int unsigned P_EXEC_CYC    = 480,
   parameter int unsigned P_CLEAR_CYC   = 19000
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_valid,
   input  logic       i_rs,
   input  logic [7:0] i_data,
   output logic       o_ready,
   output logic       o_init_done,
   output logic       o_lcd_rs,
   output logic       o_lcd_rw,
   output logic       o_lcd_e,
   output logic [7:0] o_lcd_db
);

   localparam int unsigned MAX_WAIT = max_u(max_u(max_u(P_POWERUP_CYC, P_INIT1_CYC),
                                                  max_u(P_INIT2_CYC, P_EXEC_CYC)),
                                            max_u(P_CLEAR_CYC, P_E_HIGH_CYC));
   localparam int unsigned CNT_W = $clog2(MAX_WAIT) + 1;

   // POWERUP spends its first cycle arming the timer, hence N-2.
   localparam logic [CNT_W-1:0] LD_POWERUP = CNT_W'(P_POWERUP_CYC - 2);
   localparam logic [CNT_W-1:0] LD_E_HIGH  = CNT_W'(P_E_HIGH_CYC - 1);
   localparam logic [CNT_W-1:0] LD_INIT1   = CNT_W'(P_INIT1_CYC - 1);
   localparam logic [CNT_W-1:0] LD_INIT2   = CNT_W'(P_INIT2_CYC - 1);
   localparam logic [CNT_W-1:0] LD_EXEC    = CNT_W'(P_EXEC_CYC - 1);
   localparam logic [CNT_W-1:0] LD_CLEAR   = CNT_W'(P_CLEAR_CYC - 1);
   localparam logic [2:0]       INIT_LAST  = 3'(INIT_LEN - 1);

   state_e           state_q;
   logic [2:0]       init_idx_q;
   logic             armed_q;
   logic             lcd_e_q;
   logic             lcd_rs_q;
   logic [7:0]       lcd_db_q;
   logic             ready_q;
   logic             init_done_q;

   logic             tmr_load_s;
   logic [CNT_W-1:0] tmr_load_val_s;
   logic [CNT_W-1:0] wait_cyc_s;
   logic             tmr_done_s;
   logic [CNT_W-1:0] unused_tmr_value;

   // Execution wait starts on the falling edge of E, so HOLD is its first cycle.
   always_comb begin
      wait_cyc_s = LD_EXEC;
      if (!init_done_q && (init_idx_q == 3'd0)) begin
         wait_cyc_s = LD_INIT1;
      end else if (!init_done_q && (init_idx_q == 3'd1)) begin
         wait_cyc_s = LD_INIT2;
      end else if (is_slow_cmd(lcd_rs_q, lcd_db_q)) begin
         wait_cyc_s = LD_CLEAR;
      end else begin
         wait_cyc_s = LD_EXEC;
      end
   end

   always_comb begin
      tmr_load_s     = 1'b0;
      tmr_load_val_s = {CNT_W{1'b0}};
      case (state_q)
         POWERUP: begin
            if (!armed_q) begin
               tmr_load_s     = 1'b1;
               tmr_load_val_s = LD_POWERUP;
            end else begin
               tmr_load_s     = 1'b0;
            end
         end
         SETUP: begin
            tmr_load_s     = 1'b1;
            tmr_load_val_s = LD_E_HIGH;
         end
         E_HIGH: begin
            if (tmr_done_s) begin
               tmr_load_s     = 1'b1;
               tmr_load_val_s = wait_cyc_s;
            end else begin
               tmr_load_s     = 1'b0;
            end
         end
         default: tmr_load_s = 1'b0;
      endcase
   end

   hd44780_delay_timer #(.P_WIDTH(CNT_W)) u_timer (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_load  (tmr_load_s),
      .i_value (tmr_load_val_s),
      .o_value (unused_tmr_value),
      .o_done  (tmr_done_s)
   );

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q     <= POWERUP;
         init_idx_q  <= 3'd0;
         armed_q     <= 1'b0;
         lcd_e_q     <= 1'b0;
         lcd_rs_q    <= 1'b0;
         lcd_db_q    <= 8'h00;
         ready_q     <= 1'b0;
         init_done_q <= 1'b0;
      end else begin
         case (state_q)
            POWERUP: begin
               if (!armed_q) begin
                  armed_q <= 1'b1;
               end else if (tmr_done_s) begin
                  state_q <= INIT_LOAD;
               end
            end
            INIT_LOAD: begin
               lcd_rs_q <= 1'b0;
               lcd_db_q <= init_rom(init_idx_q);
               state_q  <= SETUP;
            end
            IDLE: begin
               if (i_valid && ready_q) begin
                  lcd_rs_q <= i_rs;
                  lcd_db_q <= i_data;
                  ready_q  <= 1'b0;
                  state_q  <= SETUP;
               end
            end
            SETUP: begin
               lcd_e_q <= 1'b1;
               state_q <= E_HIGH;
            end
            E_HIGH: begin
               if (tmr_done_s) begin
                  lcd_e_q <= 1'b0;
                  state_q <= HOLD;
               end
            end
            HOLD, EXEC_WAIT: begin
               if (!tmr_done_s) begin
                  state_q <= EXEC_WAIT;
               end else if (init_done_q) begin
                  ready_q <= 1'b1;
                  state_q <= IDLE;
               end else if (init_idx_q == INIT_LAST) begin
                  init_done_q <= 1'b1;
                  ready_q     <= 1'b1;
                  state_q     <= IDLE;
               end else begin
                  init_idx_q <= init_idx_q + 3'd1;
                  state_q    <= INIT_LOAD;
               end
            end
            default: begin
               lcd_e_q <= 1'b0;
               ready_q <= 1'b0;
               state_q <= POWERUP;
            end
         endcase
      end
   end

   assign o_ready     = ready_q;
   assign o_init_done = init_done_q;
   assign o_lcd_rs    = lcd_rs_q;
   assign o_lcd_rw    = 1'b0;
   assign o_lcd_e     = lcd_e_q;
   assign o_lcd_db    = lcd_db_q;

endmodule

// File: tb/tb_hd44780_controller.sv
// Self-checking bench for hd44780_controller with reduced timing parameters;
// an E-pulse monitor feeds per-scenario tasks that compare against a timing model.
module tb_hd44780_controller;

   localparam int EH = 3;
   localparam int PU = 20;
   localparam int I1 = 10;
   localparam int I2 = 5;
   localparam int EX = 4;
   localparam int CL = 8;

   logic       clk;
   logic       rst = 1'b1;
   logic       valid = 1'b0;
   logic       rs = 1'b0;
   logic [7:0] data = 8'h00;
   logic       ready, init_done, lcd_rs, lcd_rw, lcd_e;
   logic [7:0] lcd_db;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   typedef struct {
      int         rise;
      int         fall;
      logic       rs;
      logic [7:0] db;
      bit         stable;
   } ev_t;

   ev_t        evq[$];
   ev_t        new_ev;
   logic       prev_e = 1'b0;
   logic       prev_rs = 1'b0;
   logic [7:0] prev_db = 8'h00;
   logic [7:0] init_bytes [7];
   int         init_waits [7];

   hd44780_controller #(
      .P_E_HIGH_CYC(EH), .P_POWERUP_CYC(PU), .P_INIT1_CYC(I1),
      .P_INIT2_CYC(I2), .P_EXEC_CYC(EX), .P_CLEAR_CYC(CL)
   ) dut (
      .i_clk(clk), .i_reset(rst), .i_valid(valid), .i_rs(rs), .i_data(data),
      .o_ready(ready), .o_init_done(init_done), .o_lcd_rs(lcd_rs),
      .o_lcd_rw(lcd_rw), .o_lcd_e(lcd_e), .o_lcd_db(lcd_db)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Records every E pulse: rise/fall cycle, byte, and whether RS/DB held from SETUP through HOLD.
   initial forever begin
      @(negedge clk);
      if (lcd_e && !prev_e) begin
         new_ev.rise   = cyc;
         new_ev.fall   = -1;
         new_ev.rs     = lcd_rs;
         new_ev.db     = lcd_db;
         new_ev.stable = (prev_rs == lcd_rs) && (prev_db == lcd_db);
         evq.push_back(new_ev);
      end else if (evq.size() > 0 && evq[evq.size()-1].fall < 0 && (lcd_e || prev_e)) begin
         if (lcd_rs != evq[evq.size()-1].rs || lcd_db != evq[evq.size()-1].db)
            evq[evq.size()-1].stable = 1'b0;
         if (!lcd_e)
            evq[evq.size()-1].fall = cyc;
      end
      prev_e  = lcd_e;
      prev_rs = lcd_rs;
      prev_db = lcd_db;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int exp_wait(input logic r, input logic [7:0] d);
      if (r == 1'b0 && d >= 8'h01 && d <= 8'h03) return CL;
      return EX;
   endfunction

   // Presents one byte, waits for its acceptance and for o_ready to return.
   task automatic send(input logic r, input logic [7:0] d, output int t_acc, output int t_rdy);
      valid = 1'b1; rs = r; data = d; t_acc = -1; t_rdy = -1;
      for (int k = 0; k < 200 && t_acc < 0; k++) begin
         if (ready) t_acc = cyc; else @(negedge clk);
      end
      @(negedge clk);
      valid = 1'b0;
      for (int k = 0; k < 200 && t_rdy < 0; k++) begin
         if (ready) t_rdy = cyc; else @(negedge clk);
      end
      if (t_acc < 0 || t_rdy < 0) begin
         checks++; errors++;
         $display("FAIL send_timeout: accept=%0d ready=%0d (need both >= 0)", t_acc, t_rdy);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; valid = 1'b0; rs = 1'b0; data = 8'h00;
      repeat (3) @(negedge clk);
      checks++; if (lcd_e !== 1'b0) begin errors++; $display("FAIL reset_e: got %b want 0", lcd_e); end
      checks++; if (lcd_rs !== 1'b0) begin errors++; $display("FAIL reset_rs: got %b want 0", lcd_rs); end
      checks++; if (lcd_db !== 8'h00) begin errors++; $display("FAIL reset_db: got %h want 00", lcd_db); end
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ready); end
      checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done: got %b want 0", init_done); end
      checks++; if (lcd_rw !== 1'b0) begin errors++; $display("FAIL reset_rw: got %b want 0", lcd_rw); end
   endtask

   // Releases reset with a byte already pending; it must only go out at the first o_ready.
   task automatic test_init;
      int rel, d, viol, bad_db, bad_rs, bad_stab, bad_gap, rdy;
      logic [7:0] pend;
      evq.delete();
      pend = 8'($urandom_range(32, 126));
      valid = 1'b1; rs = 1'b1; data = pend;
      rel = cyc; rst = 1'b0;
      d = -1; viol = 0;
      for (int k = 0; k < 3000 && d < 0; k++) begin
         @(negedge clk);
         if (ready && !init_done) viol++;
         if (init_done) d = cyc;
      end
      checks++; if (d < 0) begin errors++; $display("FAIL init_timeout: init_done never rose"); end
      checks++; if (viol != 0) begin errors++; $display("FAIL init_ready_early: got %0d cycles want 0", viol); end
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL init_ready: got %b want 1", ready); end
      checks++; if (evq.size() != 7) begin errors++; $display("FAIL init_count: got %0d pulses want 7", evq.size()); end
      if (evq.size() >= 7) begin
         bad_db = 0; bad_rs = 0; bad_stab = 0; bad_gap = 0;
         for (int k = 0; k < 7; k++) begin
            if (evq[k].db !== init_bytes[k]) bad_db++;
            if (evq[k].rs !== 1'b0) bad_rs++;
            if (!evq[k].stable) bad_stab++;
            if (evq[k].fall != evq[k].rise + EH) bad_gap++;
            if (k < 6 && evq[k+1].rise != evq[k].rise + EH + init_waits[k] + 2) bad_gap++;
         end
         checks++; if (bad_db != 0) begin errors++; $display("FAIL init_bytes: got %0d wrong (first %h) want 0", bad_db, evq[0].db); end
         checks++; if (bad_rs != 0) begin errors++; $display("FAIL init_rs: got %0d with rs=1 want 0", bad_rs); end
         checks++; if (bad_stab != 0) begin errors++; $display("FAIL init_stable: got %0d unstable want 0", bad_stab); end
         checks++; if (bad_gap != 0) begin errors++; $display("FAIL init_timing: got %0d bad gaps want 0", bad_gap); end
         checks++;
         if (evq[0].rise < rel + PU || evq[0].rise > rel + PU + 3) begin
            errors++; $display("FAIL init_powerup: got first E at +%0d want +%0d..+%0d", evq[0].rise - rel, PU, PU + 3);
         end
         checks++;
         if (d != evq[6].rise + EH + EX) begin
            errors++; $display("FAIL init_done_time: got %0d want %0d", d, evq[6].rise + EH + EX);
         end
      end
      @(negedge clk);
      valid = 1'b0;
      checks++; if (lcd_db !== pend || lcd_rs !== 1'b1 || ready !== 1'b0) begin
         errors++; $display("FAIL pend_setup: got db=%h rs=%b rdy=%b want db=%h rs=1 rdy=0", lcd_db, lcd_rs, ready, pend);
      end
      rdy = -1;
      for (int k = 0; k < 200 && rdy < 0; k++) begin
         if (ready) rdy = cyc; else @(negedge clk);
      end
      checks++; if (rdy != d + EH + 2 + EX) begin errors++; $display("FAIL pend_ready: got %0d want %0d", rdy, d + EH + 2 + EX); end
      checks++;
      if (evq.size() != 8 || evq[evq.size()-1].rise != d + 2 || evq[evq.size()-1].db !== pend) begin
         errors++; $display("FAIL pend_pulse: got %0d pulses want 8 with byte %h at %0d", evq.size(), pend, d + 2);
      end
      checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL init_sticky: got %b want 1", init_done); end
   endtask

   task automatic test_data_write;
      int t, bad_e, first_rdy;
      logic e_s [13];
      logic r_s [13];
      for (int k = 0; k < 200 && !ready; k++) @(negedge clk);
      valid = 1'b1; rs = 1'b1; data = 8'h41; t = cyc;
      @(negedge clk);
      valid = 1'b0; rs = 1'b0; data = 8'($urandom);
      checks++; if (lcd_db !== 8'h41 || lcd_rs !== 1'b1 || lcd_e !== 1'b0 || ready !== 1'b0) begin
         errors++; $display("FAIL write_setup: got db=%h rs=%b e=%b rdy=%b want 41 1 0 0", lcd_db, lcd_rs, lcd_e, ready);
      end
      for (int k = 2; k <= 12; k++) begin
         @(negedge clk);
         e_s[k] = lcd_e; r_s[k] = ready;
      end
      bad_e = 0; first_rdy = -1;
      for (int k = 2; k <= 12; k++) begin
         if (e_s[k] !== ((k >= 2 && k < 2 + EH) ? 1'b1 : 1'b0)) bad_e++;
         if (first_rdy < 0 && r_s[k] === 1'b1) first_rdy = k;
      end
      checks++; if (bad_e != 0) begin errors++; $display("FAIL write_e_window: got %0d wrong cycles want 0", bad_e); end
      checks++; if (first_rdy != 9) begin errors++; $display("FAIL write_ready: got t+%0d want t+9", first_rdy); end
      checks++; if (lcd_db !== 8'h41 || lcd_rs !== 1'b1) begin
         errors++; $display("FAIL write_keep: got db=%h rs=%b want 41 1", lcd_db, lcd_rs);
      end
   endtask

   task automatic test_cmd_waits;
      int ta, tr;
      logic [7:0] cmds [4];
      logic       rss  [4];
      cmds[0] = 8'h01; rss[0] = 1'b0;
      cmds[1] = 8'h80; rss[1] = 1'b0;
      cmds[2] = 8'($urandom_range(2, 3)); rss[2] = 1'b0;
      cmds[3] = 8'h01; rss[3] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         send(rss[i], cmds[i], ta, tr);
         checks++;
         if (tr - ta != EH + 2 + exp_wait(rss[i], cmds[i])) begin
            errors++; $display("FAIL cmd_wait_%h_rs%b: got %0d want %0d", cmds[i], rss[i], tr - ta, EH + 2 + exp_wait(rss[i], cmds[i]));
         end
      end
   endtask

   task automatic test_valid_during_wait;
      int t, t2, n0, rdy;
      logic [7:0] b;
      b = 8'($urandom_range(32, 126));
      for (int k = 0; k < 200 && !ready; k++) @(negedge clk);
      n0 = evq.size();
      valid = 1'b1; rs = 1'b0; data = 8'h80; t = cyc;
      @(negedge clk);
      rs = 1'b1; data = b;
      t2 = -1;
      for (int k = 0; k < 200 && t2 < 0; k++) begin
         if (ready) t2 = cyc; else @(negedge clk);
      end
      checks++; if (t2 != t + EH + 2 + EX) begin errors++; $display("FAIL busy_accept: got %0d want %0d", t2, t + EH + 2 + EX); end
      checks++; if (evq.size() != n0 + 1) begin errors++; $display("FAIL busy_ignore: got %0d pulses want %0d", evq.size() - n0, 1); end
      @(negedge clk);
      valid = 1'b0;
      rdy = -1;
      for (int k = 0; k < 200 && rdy < 0; k++) begin
         if (ready) rdy = cyc; else @(negedge clk);
      end
      checks++;
      if (evq.size() != n0 + 2 || evq[evq.size()-1].db !== b || evq[evq.size()-1].rs !== 1'b1 || evq[evq.size()-1].rise != t2 + 2) begin
         errors++; $display("FAIL busy_byte: got %0d pulses want %0d with %h at %0d", evq.size() - n0, 2, b, t2 + 2);
      end
   endtask

   task automatic test_back_to_back;
      int ta, tr, prev_tr, n0, bad_lat, bad_gap, bad_ev;
      logic       r;
      logic [7:0] d;
      bad_lat = 0; bad_gap = 0; bad_ev = 0; prev_tr = -1;
      for (int i = 0; i < 10; i++) begin
         r = 1'($urandom_range(0, 1));
         d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom_range(0, 255));
         n0 = evq.size();
         send(r, d, ta, tr);
         if (tr - ta != EH + 2 + exp_wait(r, d)) bad_lat++;
         if (prev_tr >= 0 && ta != prev_tr) bad_gap++;
         if (evq.size() != n0 + 1) bad_ev++;
         else if (evq[n0].db !== d || evq[n0].rs !== r || evq[n0].rise != ta + 2 ||
                  evq[n0].fall != ta + 2 + EH || !evq[n0].stable) bad_ev++;
         prev_tr = tr;
      end
      checks++; if (bad_lat != 0) begin errors++; $display("FAIL b2b_latency: got %0d wrong want 0", bad_lat); end
      checks++; if (bad_gap != 0) begin errors++; $display("FAIL b2b_gap: got %0d gaps want 0", bad_gap); end
      checks++; if (bad_ev != 0) begin errors++; $display("FAIL b2b_pulse: got %0d wrong pulses want 0", bad_ev); end
   endtask

   task automatic test_reset_mid_pulse;
      for (int k = 0; k < 200 && !ready; k++) @(negedge clk);
      valid = 1'b1; rs = 1'b1; data = 8'($urandom);
      @(negedge clk);
      valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++; if (lcd_e !== 1'b1) begin errors++; $display("FAIL midpulse_e_before: got %b want 1", lcd_e); end
      #2 rst = 1'b1;
      #1;
      checks++; if (lcd_e !== 1'b0 || lcd_rs !== 1'b0 || lcd_db !== 8'h00 || ready !== 1'b0 || init_done !== 1'b0) begin
         errors++; $display("FAIL midpulse_reset: got e=%b rs=%b db=%h rdy=%b done=%b want all 0", lcd_e, lcd_rs, lcd_db, ready, init_done);
      end
      @(negedge clk);
      @(negedge clk);
      checks++; if (lcd_e !== 1'b0) begin errors++; $display("FAIL midpulse_e_held: got %b want 0", lcd_e); end
      test_init();
   endtask

   initial begin
      init_bytes[0] = 8'h38; init_bytes[1] = 8'h38; init_bytes[2] = 8'h38; init_bytes[3] = 8'h38;
      init_bytes[4] = 8'h0C; init_bytes[5] = 8'h01; init_bytes[6] = 8'h06;
      init_waits[0] = I1; init_waits[1] = I2; init_waits[2] = EX; init_waits[3] = EX;
      init_waits[4] = EX; init_waits[5] = CL; init_waits[6] = EX;
      @(negedge clk);
      test_reset();
      test_init();
      test_data_write();
      test_cmd_waits();
      test_valid_during_wait();
      test_back_to_back();
      test_reset_mid_pulse();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hd44780_controller.md
HD44780_CONTROLLER -- requirements
Module: hd44780_controller

Interface
REQ-001 SHALL have parameter P_E_HIGH_CYC, default 7: E-high width in i_clk cycles (7 × 83 ns ≈ 580 ns).
REQ-002 SHALL have parameter P_POWERUP_CYC, default 200000: post-reset wait before first init command (≈16.7 ms at 12 MHz).
REQ-003 SHALL have parameter P_INIT1_CYC, default 50000: wait after first init function-set (≈4.1 ms).
REQ-004 SHALL have parameter P_INIT2_CYC, default 1200: wait after second init function-set (≈100 us).
REQ-005 SHALL have parameter P_EXEC_CYC, default 480: execution wait for normal commands and data (≈40 us).
REQ-006 SHALL have parameter P_CLEAR_CYC, default 19000: execution wait for clear/home commands (≈1.6 ms).
REQ-007 SHALL have port i_clk, input, 1: single clock for all logic.
REQ-008 SHALL have port i_reset, input, 1: asynchronous, active-high reset.
REQ-009 SHALL have port i_valid, input, 1: requester has a byte to write.
REQ-010 SHALL have port i_rs, input, 1: 0 = command, 1 = character data.
REQ-011 SHALL have port i_data, input, 8: byte to write.
REQ-012 SHALL have port o_ready, output, 1: controller accepts a byte this cycle.
REQ-013 SHALL have port o_init_done, output, 1: init sequence completed.
REQ-014 SHALL have ports o_lcd_rs (output, 1), o_lcd_rw (output, 1, constant 0), o_lcd_e (output, 1) and o_lcd_db (output, 8), all driving the LCD pins.

Function
REQ-015 SHALL use FSM states POWERUP, INIT_LOAD, IDLE, SETUP, E_HIGH, HOLD and EXEC_WAIT.
REQ-016 SHALL start in POWERUP after reset, wait P_POWERUP_CYC cycles, then enter INIT_LOAD.
REQ-017 SHALL issue the init ROM in order, all with RS = 0:
- 0x38, then wait P_INIT1_CYC
- 0x38, then wait P_INIT2_CYC
- 0x38, 0x38, 0x0C, each then wait P_EXEC_CYC
- 0x01, then wait P_CLEAR_CYC
- 0x06, then wait P_EXEC_CYC
REQ-018 SHALL, after the last init wait, set o_init_done = 1 and enter IDLE; o_init_done stays 1 until reset.
REQ-019 SHALL assert o_ready only in IDLE, and never while o_init_done = 0.
REQ-020 SHALL capture a transfer only when i_valid & o_ready; i_valid while o_ready = 0 is ignored and leaves no side effect.
REQ-021 SHALL, for a transfer accepted at cycle t:
- update o_lcd_rs / o_lcd_db at t+1 (SETUP, E low);
- raise o_lcd_e at t+2 and hold it high exactly P_E_HIGH_CYC cycles;
- drop E for one HOLD cycle with RS/DB unchanged;
- then enter EXEC_WAIT.
REQ-022 SHALL use the P_CLEAR_CYC wait when RS = 0 and data ∈ {0x01, 0x02, 0x03}, and P_EXEC_CYC otherwise.
REQ-023 SHALL return to IDLE (o_ready = 1) on the cycle after the wait counter expires; back-to-back transfers are therefore allowed with no extra gap.
REQ-024 SHALL hold o_lcd_rs / o_lcd_db stable from SETUP through HOLD, and keep their last values outside that window.
REQ-025 SHALL use the same SETUP/E_HIGH/HOLD path for init bytes as for user bytes.
REQ-026 SHALL size the wait counter at $clog2 of the largest wait parameter plus 1.
REQ-027 SHALL load the wait counter with N−1 and finish at 0, so a wait of N gives exactly N cycles.
REQ-028 SHALL have o_lcd_e high only in E_HIGH.

Reset
REQ-029 SHALL, on i_reset, immediately force: o_lcd_e = 0, o_lcd_rs = 0, o_lcd_db = 0x00, o_ready = 0, o_init_done = 0, state = POWERUP, init index = 0, counter = 0.
REQ-030 SHALL, when reset is asserted mid-pulse or mid-wait, abort the transfer with no E glitch and rerun the full init after release.

Structure
REQ-031 SHALL place the following in shared package hd44780_pkg:
- state enum;
- command constants CMD_FUNC_SET_8B2L = 8'h38, CMD_DISPLAY_ON = 8'h0C, CMD_CLEAR = 8'h01, CMD_ENTRY_INC = 8'h06;
- init ROM length 7.
REQ-032 SHALL instantiate one sub-module, hd44780_delay_timer, a loadable down-counter with load, value and done outputs.

Verification
REQ-033 Bench SHALL cover each of the following directed scenarios, using reduced parameters (POWERUP = 20, INIT1 = 10, INIT2 = 5, EXEC = 4, CLEAR = 8, E_HIGH = 3):
- Reset release -> 7 E-pulses carrying bytes 38,38,38,38,0C,01,06 with RS = 0; gaps per REQ-017; o_init_done rises after the 0x06 wait.
- Data write: i_rs = 1, i_data = 0x41 accepted at t -> DB = 0x41 / RS = 1 at t+1; E high t+2..t+4; o_ready back at t+9.
- Command 0x01 -> 8-cycle EXEC wait.
- Command 0x80 -> 4-cycle EXEC wait.
- i_valid held during init and during EXEC_WAIT -> no capture; the byte is accepted only at the first o_ready.
- Reset asserted mid E_HIGH -> E = 0 in the same cycle; init sequence reruns from the start.
